// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch: one outstanding imem request, decoded handoff over valid/ready.
// Optional performance counters are built when IFU_FETCH_PERF_EN is defined.
module ifu_fetch #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] PC_RST_VEC = 32'h80000000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            pc_branch,
    input  logic [XLEN-1:0] target_pc,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        VALID
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            req_next;
    logic            valid_next;
    logic            capture;
    logic            fire;
    logic [XLEN-1:0] pc;

    // The address bus is the PC register itself, so it is held stable through REQ.
    assign imem_addr = pc;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        fire       = 1'b0;
        unique case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem_ack) begin
                    capture    = 1'b1;
                    state_next = VALID;
                end
            end
            VALID: begin
                if (inst_ready) begin
                    fire       = 1'b1;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
        // Handshake outputs are registered copies of the next-state decode.
        req_next   = (state_next == REQ);
        valid_next = (state_next == VALID);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            pc         <= PC_RST_VEC;
        end else begin
            state      <= state_next;
            imem_req   <= req_next;
            inst_valid <= valid_next;
            if (capture) begin
                inst    <= imem_rdata;
                inst_pc <= pc;
            end
            if (fire) begin
                pc <= pc_branch ? {target_pc[XLEN-1:2], 2'b00} : pc + XLEN'(4);
            end
        end
    end

`ifdef IFU_FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fire) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if ((state == REQ) && !imem_ack) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt;
    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: fetched words are queued on ack and checked when decode consumes them.
module tb_ifu_fetch;

    localparam logic [31:0] RST_VEC = 32'h80000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        pc_branch;
    logic [31:0] target_pc;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    logic [31:0] exp_stall;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    ifu_fetch #(
        .XLEN      (32),
        .PC_RST_VEC(RST_VEC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .pc_branch     (pc_branch),
        .target_pc     (target_pc),
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_perf(input string tag);
`ifdef IFU_FETCH_PERF_EN
        chk({tag, "_fetch_cnt"}, 64'(perf_fetch_cnt), 64'(exp_fetch));
        chk({tag, "_stall_cnt"}, 64'(perf_stall_cnt), 64'(exp_stall));
`else
        chk({tag, "_fetch_cnt_tied"}, 64'(perf_fetch_cnt), 64'd0);
        chk({tag, "_stall_cnt_tied"}, 64'(perf_stall_cnt), 64'd0);
`endif
    endtask

    // One full transaction; entered and left just after a falling edge.
    task automatic fetch(input int unsigned stall, input int unsigned hold,
                         input logic br, input logic [31:0] tgt);
        int unsigned n;
        logic [31:0] word;
        logic [63:0] head;
        n = 0;
        while (!imem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 64'(imem_req), 64'd1);
        chk("req_addr", 64'(imem_addr), 64'(exp_pc));
        for (int unsigned i = 0; i < stall; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
            chk("stall_req", 64'(imem_req), 64'd1);
            chk("stall_addr", 64'(imem_addr), 64'(exp_pc));
            chk("stall_valid", 64'(inst_valid), 64'd0);
        end
        exp_stall  = exp_stall + stall;
        word       = $urandom;
        imem_ack   = 1'b1;
        imem_rdata = word;
        sb.push_back({word, exp_pc});
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("valid_after_ack", 64'(inst_valid), 64'd1);
        chk("req_drop", 64'(imem_req), 64'd0);
        for (int unsigned i = 0; i < hold; i++) begin
            inst_ready = 1'b0;
            pc_branch  = 1'b1;
            target_pc  = $urandom;
            @(negedge clk);
            chk("hold_valid", 64'(inst_valid), 64'd1);
            chk("hold_req", 64'(imem_req), 64'd0);
            if (sb.size() != 0) begin
                head = sb[0];
                chk("hold_inst", 64'(inst), 64'(head[63:32]));
                chk("hold_pc", 64'(inst_pc), 64'(head[31:0]));
            end
        end
        inst_ready = 1'b1;
        pc_branch  = br;
        target_pc  = tgt;
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            head = sb.pop_front();
            chk("inst", 64'(inst), 64'(head[63:32]));
            chk("inst_pc", 64'(inst_pc), 64'(head[31:0]));
        end
        exp_pc    = br ? (tgt & 32'hFFFF_FFFC) : exp_pc + 32'd4;
        exp_fetch = exp_fetch + 32'd1;
        @(negedge clk);
        inst_ready = 1'b0;
        pc_branch  = 1'b0;
        target_pc  = '0;
        chk("valid_after_fire", 64'(inst_valid), 64'd0);
        chk("req_after_fire", 64'(imem_req), 64'd1);
        chk("addr_after_fire", 64'(imem_addr), 64'(exp_pc));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"}, 64'(imem_req), 64'd0);
        chk({tag, "_addr"}, 64'(imem_addr), 64'(RST_VEC));
        chk({tag, "_valid"}, 64'(inst_valid), 64'd0);
        chk({tag, "_inst"}, 64'(inst), 64'd0);
        chk({tag, "_inst_pc"}, 64'(inst_pc), 64'd0);
        chk_perf(tag);
    endtask

    initial begin
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        inst_ready = 1'b0;
        pc_branch  = 1'b0;
        target_pc  = '0;
        exp_pc     = RST_VEC;
        exp_fetch  = '0;
        exp_stall  = '0;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", 64'(imem_req), 64'd1);

        // Zero-wait memory, decode always ready.
        fetch(0, 0, 1'b0, '0);
        fetch(0, 0, 1'b0, '0);
        fetch(0, 0, 1'b0, '0);
        chk_perf("seq");

        fetch(3, 0, 1'b0, '0);
        chk_perf("stall3");

        fetch(0, 5, 1'b0, '0);
        chk_perf("hold5");

        // Misaligned branch target aligned down.
        fetch(0, 2, 1'b1, 32'h80000103);
        chk("branch_addr", 64'(imem_addr), 64'h80000100);
        fetch(1, 0, 1'b0, '0);

        // PC wrap at the top of the address space.
        fetch(0, 0, 1'b1, 32'hFFFFFFFE);
        chk("wrap_top_addr", 64'(imem_addr), 64'hFFFFFFFC);
        fetch(0, 0, 1'b0, '0);
        chk("wrap_zero_addr", 64'(imem_addr), 64'h00000000);
        fetch(2, 1, 1'b0, '0);
        chk_perf("wrap");

        // Reset while in REQ, late ack arrives the cycle after.
        chk("pre_rst_req", 64'(imem_req), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        exp_pc    = RST_VEC;
        exp_fetch = '0;
        exp_stall = '0;
        check_reset_values("mid_req_rst");
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("late_ack_valid", 64'(inst_valid), 64'd0);
        chk("refetch_req", 64'(imem_req), 64'd1);
        chk("refetch_addr", 64'(imem_addr), 64'(RST_VEC));
        @(negedge clk);
        exp_stall = exp_stall + 32'd1;
        chk("late_ack_ignored", 64'(inst_valid), 64'd0);
        chk("refetch_req_hold", 64'(imem_req), 64'd1);
        fetch(0, 0, 1'b0, '0);
        fetch(0, 0, 1'b0, '0);
        chk_perf("after_rst");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
